// File: rtl/addsub_acc_seq_if.sv
// Bundle of request, add/sub-stage and response signals for addsub_acc_seq.
interface addsub_acc_seq_if #(
    parameter int unsigned W = 16
);
    // Request handshake
    logic           in_valid;
    logic           in_ready;
    logic [1:0]     in_op;
    logic [W-1:0]   in_data;

    // Combinational add/sub stage
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic           add_cin;
    logic           add_sub;
    logic [W-1:0]   add_sum;
    logic           add_cout;

    // Response handshake
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [3:0]     out_flags;

    // Accumulator side
    modport slave (
        input  in_valid, in_op, in_data, add_sum, add_cout, out_ready,
        output in_ready, add_a, add_b, add_cin, add_sub, out_valid, out_data, out_flags
    );

    // Requester / consumer / add-stage side
    modport master (
        output in_valid, in_op, in_data, add_sum, add_cout, out_ready,
        input  in_ready, add_a, add_b, add_cin, add_sub, out_valid, out_data, out_flags
    );
endinterface

// File: rtl/addsub_acc_seq.sv
// Registered, flow-controlled accumulator wrapped around an external
// combinational add/sub stage: accept op -> drive stage -> capture -> respond.
module addsub_acc_seq #(
    parameter int unsigned W   = 16,
    parameter bit          SAT = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    addsub_acc_seq_if.slave   bus
);

    localparam int unsigned FW = 4;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_EXEC = 2'b01;
    localparam logic [1:0] S_RESP = 2'b10;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] MOST_POS = {1'b0, {(W-1){1'b1}}};

    logic [1:0]     state_q,     state_d;
    logic [W-1:0]   acc_q,       acc_d;
    logic [W-1:0]   opnd_q,      opnd_d;
    logic [1:0]     op_q,        op_d;
    logic           sub_q,       sub_d;
    logic           in_ready_q,  in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_data_q,  out_data_d;
    logic [FW-1:0]  flags_q,     flags_d;

    logic [W-1:0]   res_c;
    logic           carry_c;
    logic           ovf_c;

    // Result of the op in EXEC: new accumulator value, carry and signed overflow
    always_comb begin
        res_c   = acc_q;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        case (op_q)
            OP_LOAD: begin
                res_c = opnd_q;
            end
            OP_ADD: begin
                res_c   = bus.add_sum;
                carry_c = bus.add_cout;
                ovf_c   = (acc_q[W-1] == opnd_q[W-1]) && (bus.add_sum[W-1] != acc_q[W-1]);
            end
            OP_SUB: begin
                res_c   = bus.add_sum;
                carry_c = bus.add_cout;
                ovf_c   = (acc_q[W-1] != opnd_q[W-1]) && (bus.add_sum[W-1] != acc_q[W-1]);
            end
            default: begin
                res_c = '0;
            end
        endcase
        // Clamp toward the sign of the original accumulator; V stays reported
        if (SAT && ovf_c) begin
            res_c = acc_q[W-1] ? MOST_NEG : MOST_POS;
        end
    end

    // Next-state and next-register values for IDLE -> EXEC -> RESP -> IDLE
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        opnd_d      = opnd_q;
        op_d        = op_q;
        sub_d       = sub_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        flags_d     = flags_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    op_d       = bus.in_op;
                    opnd_d     = bus.in_data;
                    sub_d      = (bus.in_op == OP_SUB);
                    in_ready_d = 1'b0;
                    state_d    = S_EXEC;
                end
            end
            S_EXEC: begin
                acc_d       = res_c;
                out_data_d  = res_c;
                flags_d     = {carry_c, ovf_c, res_c[W-1], (res_c == '0)};
                out_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            opnd_q      <= '0;
            op_q        <= OP_LOAD;
            sub_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            opnd_q      <= opnd_d;
            op_q        <= op_d;
            sub_q       <= sub_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            flags_q     <= flags_d;
        end
    end

    // Add/sub stage is fed straight from registers, so it holds outside EXEC
    assign bus.add_a     = acc_q;
    assign bus.add_b     = opnd_q;
    assign bus.add_sub   = sub_q;
    assign bus.add_cin   = 1'b0;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_flags = flags_q;

endmodule

// File: tb/tb_addsub_acc_seq.sv
// Bench for addsub_acc_seq: wrap (SAT=0) and saturating (SAT=1) instances
// driven with identical traffic, each with its own behavioural add/sub stage.
module tb_addsub_acc_seq;

    localparam int unsigned W = 16;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] data;
        logic [15:0] exp_d0;
        logic [3:0]  exp_f0;
        logic [15:0] exp_d1;
        logic [3:0]  exp_f1;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    addsub_acc_seq_if #(.W(W)) b0 ();
    addsub_acc_seq_if #(.W(W)) b1 ();

    addsub_acc_seq #(.W(W), .SAT(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    addsub_acc_seq #(.W(W), .SAT(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    // Behavioural add/sub stages: subtract is a + ~b + 1, carry = bit W
    assign {b0.add_cout, b0.add_sum} = b0.add_sub
        ? (17'({1'b0, b0.add_a}) + 17'({1'b0, ~b0.add_b}) + 17'd1)
        : (17'({1'b0, b0.add_a}) + 17'({1'b0, b0.add_b}));
    assign {b1.add_cout, b1.add_sum} = b1.add_sub
        ? (17'({1'b0, b1.add_a}) + 17'({1'b0, ~b1.add_b}) + 17'd1)
        : (17'({1'b0, b1.add_a}) + 17'({1'b0, b1.add_b}));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic v, input logic [1:0] op, input logic [15:0] data);
        b0.in_valid = v; b0.in_op = op; b0.in_data = data;
        b1.in_valid = v; b1.in_op = op; b1.in_data = data;
    endtask

    task automatic set_out_ready(input logic r);
        b0.out_ready = r;
        b1.out_ready = r;
    endtask

    // Present a request in IDLE, take the accept edge, confirm EXEC state
    task automatic accept(input logic [1:0] op, input logic [15:0] data, input string tag);
        chk({tag, " in_ready idle0"}, 16'(b0.in_ready), 16'd1);
        chk({tag, " in_ready idle1"}, 16'(b1.in_ready), 16'd1);
        drive_req(1'b1, op, data);
        tick();
        drive_req(1'b0, ~op, 16'hDEAD);
        chk({tag, " in_ready exec0"},  16'(b0.in_ready),  16'd0);
        chk({tag, " out_valid exec0"}, 16'(b0.out_valid), 16'd0);
        chk({tag, " out_valid exec1"}, 16'(b1.out_valid), 16'd0);
    endtask

    // End of EXEC: result must be presented on this edge
    task automatic exec_edge(input string tag);
        tick();
        chk({tag, " out_valid0"}, 16'(b0.out_valid), 16'd1);
        chk({tag, " out_valid1"}, 16'(b1.out_valid), 16'd1);
    endtask

    // Complete the response handshake and expect IDLE on the next edge
    task automatic release_resp(input string tag);
        set_out_ready(1'b1);
        tick();
        chk({tag, " out_valid done0"}, 16'(b0.out_valid), 16'd0);
        chk({tag, " out_valid done1"}, 16'(b1.out_valid), 16'd0);
        chk({tag, " in_ready done0"},  16'(b0.in_ready),  16'd1);
        chk({tag, " in_ready done1"},  16'(b1.in_ready),  16'd1);
    endtask

    task automatic check_result(input string tag, input logic [15:0] d0, input logic [3:0] f0,
                                input logic [15:0] d1, input logic [3:0] f1);
        chk({tag, " data0"},  b0.out_data,         d0);
        chk({tag, " flags0"}, 16'(b0.out_flags),   16'(f0));
        chk({tag, " data1"},  b1.out_data,         d1);
        chk({tag, " flags1"}, 16'(b1.out_flags),   16'(f1));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        // Flags are {C,V,N,Z}; d0/f0 wrap instance, d1/f1 saturating instance
        vecs[0]  = '{OP_LOAD,  16'h0001, 16'h0001, 4'b0000, 16'h0001, 4'b0000};
        vecs[1]  = '{OP_ADD,   16'h0001, 16'h0002, 4'b0000, 16'h0002, 4'b0000};
        vecs[2]  = '{OP_LOAD,  16'h8000, 16'h8000, 4'b0010, 16'h8000, 4'b0010};
        vecs[3]  = '{OP_ADD,   16'h8001, 16'h0001, 4'b1100, 16'h8000, 4'b1110};
        vecs[4]  = '{OP_LOAD,  16'h4000, 16'h4000, 4'b0000, 16'h4000, 4'b0000};
        vecs[5]  = '{OP_SUB,   16'h0005, 16'h3FFB, 4'b1000, 16'h3FFB, 4'b1000};
        vecs[6]  = '{OP_LOAD,  16'h8000, 16'h8000, 4'b0010, 16'h8000, 4'b0010};
        vecs[7]  = '{OP_SUB,   16'h0001, 16'h7FFF, 4'b1100, 16'h8000, 4'b1110};
        vecs[8]  = '{OP_LOAD,  16'h0001, 16'h0001, 4'b0000, 16'h0001, 4'b0000};
        vecs[9]  = '{OP_SUB,   16'h0001, 16'h0000, 4'b1001, 16'h0000, 4'b1001};
        vecs[10] = '{OP_LOAD,  16'h1234, 16'h1234, 4'b0000, 16'h1234, 4'b0000};
        vecs[11] = '{OP_CLEAR, 16'hFFFF, 16'h0000, 4'b0001, 16'h0000, 4'b0001};
        vecs[12] = '{OP_ADD,   16'h7FFF, 16'h7FFF, 4'b0000, 16'h7FFF, 4'b0000};
        vecs[13] = '{OP_ADD,   16'h0001, 16'h8000, 4'b0110, 16'h7FFF, 4'b0100};

        rst_n = 1'b0;
        drive_req(1'b0, OP_LOAD, 16'h0000);
        set_out_ready(1'b0);
        tick();
        tick();

        // Reset state
        chk("rst in_ready",  16'(b0.in_ready),  16'd1);
        chk("rst out_valid", 16'(b0.out_valid), 16'd0);
        chk("rst out_data",  b0.out_data,       16'h0000);
        chk("rst out_flags", 16'(b0.out_flags), 16'd0);
        chk("rst add_a",     b0.add_a,          16'h0000);
        chk("rst add_b",     b0.add_b,          16'h0000);
        chk("rst add_sub",   16'(b0.add_sub),   16'd0);
        chk("rst add_cin",   16'(b0.add_cin),   16'd0);
        chk("rst out_valid1", 16'(b1.out_valid), 16'd0);
        rst_n = 1'b1;
        tick();

        // Table: out_ready held high throughout, ignored until RESP
        set_out_ready(1'b1);
        for (int i = 0; i < NV; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            accept(vecs[i].op, vecs[i].data, tag);
            if (vecs[i].op == OP_SUB)
                chk({tag, " add_sub"}, 16'(b0.add_sub), 16'd1);
            else
                chk({tag, " add_sub"}, 16'(b0.add_sub), 16'd0);
            chk({tag, " add_cin"}, 16'(b0.add_cin), 16'd0);
            exec_edge(tag);
            check_result(tag, vecs[i].exp_d0, vecs[i].exp_f0, vecs[i].exp_d1, vecs[i].exp_f1);
            release_resp(tag);
        end

        // Back-pressure: result held 5 cycles with a competing request present
        set_out_ready(1'b0);
        accept(OP_LOAD, 16'h8000, "bp load");
        exec_edge("bp load");
        release_resp("bp load");
        set_out_ready(1'b0);
        accept(OP_ADD, 16'h8000, "bp add");
        exec_edge("bp add");
        drive_req(1'b1, OP_LOAD, 16'hFFFF);
        for (int k = 0; k < 5; k++) begin
            string tag;
            tag = $sformatf("bp hold%0d", k);
            check_result(tag, 16'h0000, 4'b1101, 16'h8000, 4'b1110);
            chk({tag, " out_valid"}, 16'(b0.out_valid), 16'd1);
            chk({tag, " in_ready"},  16'(b0.in_ready),  16'd0);
            chk({tag, " in_ready1"}, 16'(b1.in_ready),  16'd0);
            tick();
        end
        // Competing request still asserted on the release edge: must not be taken
        release_resp("bp release");
        drive_req(1'b0, OP_LOAD, 16'h0000);
        accept(OP_ADD, 16'h0000, "bp after");
        exec_edge("bp after");
        check_result("bp after", 16'h0000, 4'b0001, 16'h8000, 4'b0010);
        release_resp("bp after");

        // Reset during EXEC discards the op
        accept(OP_LOAD, 16'h5555, "rx");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rx out_valid0", 16'(b0.out_valid), 16'd0);
        chk("rx out_valid1", 16'(b1.out_valid), 16'd0);
        chk("rx in_ready0",  16'(b0.in_ready),  16'd1);
        chk("rx acc0",       b0.add_a,          16'h0000);
        chk("rx acc1",       b1.add_a,          16'h0000);
        tick();
        chk("rx still idle", 16'(b0.out_valid), 16'd0);
        accept(OP_ADD, 16'h0003, "rx add");
        exec_edge("rx add");
        check_result("rx add", 16'h0003, 4'b0000, 16'h0003, 4'b0000);
        release_resp("rx add");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
